// File: rtl/mood_reporter.sv
// Serialises {emotion, status} snapshots from the mood core as 4-byte UART 8N1 frames
// (A5, emotion, status, checksum), on change or on an idle heartbeat.
module mood_reporter #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned HEARTBEAT    = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] emotion,
    input  logic [7:0] status,
    output logic       tx,
    output logic       busy,
    output logic [7:0] frames_sent
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned HB_W  = (HEARTBEAT > 1) ? $clog2(HEARTBEAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [HB_W-1:0]  HB_LAST  = HB_W'((HEARTBEAT > 0) ? (HEARTBEAT - 1) : 0);
    localparam logic [HB_W-1:0]  HB_ONE   = HB_W'(1);
    localparam bit               HB_EN    = (HEARTBEAT != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    function automatic logic [7:0] checksum(input logic [15:0] snap);
        return 8'hA5 ^ snap[15:8] ^ snap[7:0];
    endfunction

    function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [15:0] snap);
        case (idx)
            2'd0:    return 8'hA5;
            2'd1:    return snap[15:8];
            2'd2:    return snap[7:0];
            default: return checksum(snap);
        endcase
    endfunction

    logic [15:0]      sync1_q, sync2_q, prev_q, last_sent_q;
    logic             go_q;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [1:0]       byte_q;
    logic [7:0]       shift_q;
    logic [HB_W-1:0]  hb_q, hb_d;
    logic             hb_hit;
    logic             tx_q, busy_q;
    logic [7:0]       frames_q;

    // Two-flop synchroniser, previous-value register and a registered change trigger;
    // the trigger stage is what places the start bit four edges after capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 16'h0000;
            sync2_q <= 16'h0000;
            prev_q  <= 16'h0000;
            go_q    <= 1'b0;
        end else begin
            sync1_q <= {emotion, status};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            go_q    <= (sync2_q == prev_q) && (sync2_q != last_sent_q);
        end
    end

    // Heartbeat next value: saturates at the terminal count until a frame clears it.
    always_comb begin
        hb_d   = hb_q;
        hb_hit = 1'b0;
        if (HB_EN) begin
            hb_hit = (hb_q == HB_LAST);
            if (!hb_hit) begin
                hb_d = hb_q + HB_ONE;
            end else begin
                hb_d = hb_q;
            end
        end else begin
            hb_hit = 1'b0;
        end
    end

    // Frame FSM; prev_q holds the exact value the start decision was based on,
    // so it is the snapshot latched into last_sent_q for the whole frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= 3'd0;
            byte_q      <= 2'd0;
            shift_q     <= 8'hFF;
            last_sent_q <= 16'h0000;
            hb_q        <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            frames_q    <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go_q || hb_hit) begin
                        state_q     <= START;
                        cnt_q       <= '0;
                        byte_q      <= 2'd0;
                        shift_q     <= 8'hA5;
                        last_sent_q <= prev_q;
                        hb_q        <= '0;
                        tx_q        <= 1'b0;
                        busy_q      <= 1'b1;
                    end else begin
                        hb_q   <= hb_d;
                        tx_q   <= 1'b1;
                        busy_q <= 1'b0;
                    end
                end
                START: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        bit_q   <= 3'd0;
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= shift_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (byte_q == 2'd3) begin
                            state_q  <= IDLE;
                            busy_q   <= 1'b0;
                            frames_q <= frames_q + 8'd1;
                        end else begin
                            byte_q  <= byte_q + 2'd1;
                            shift_q <= frame_byte(byte_q + 2'd1, last_sent_q);
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx          = tx_q;
    assign busy        = busy_q;
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_mood_reporter.sv
// Scoreboard bench for mood_reporter: expected frame bytes are queued at stimulus time
// and checked by a UART monitor decoding tx.
module tb_mood_reporter;

    localparam int CPB = 4;
    localparam int HB  = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] emotion, status;
    logic       tx, busy, tx0, busy0;
    logic [7:0] frames_sent, frames_sent0;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    bit         sb_mode   = 1'b1;
    bit         mon_abort = 1'b0;
    bit         cnt0_en   = 1'b0;
    int         busy0_cnt = 0;

    mood_reporter #(.CLKS_PER_BIT(CPB), .HEARTBEAT(HB)) dut (
        .clk(clk), .rst(rst), .emotion(emotion), .status(status),
        .tx(tx), .busy(busy), .frames_sent(frames_sent)
    );

    mood_reporter #(.CLKS_PER_BIT(CPB), .HEARTBEAT(0)) dut_nohb (
        .clk(clk), .rst(rst), .emotion(emotion), .status(status),
        .tx(tx0), .busy(busy0), .frames_sent(frames_sent0)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (cnt0_en && busy0) busy0_cnt <= busy0_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] e, input logic [7:0] s);
        exp_q.push_back(8'hA5);
        exp_q.push_back(e);
        exp_q.push_back(s);
        exp_q.push_back(8'hA5 ^ e ^ s);
    endtask

    // Counts negedges until busy reaches lvl; must be called on a negedge.
    task automatic wait_level(input logic lvl, input int max, output int cnt);
        cnt = 0;
        while (busy !== lvl && cnt < max) begin
            cnt++;
            @(negedge clk);
        end
        check_val("wait_busy", {31'd0, busy}, {31'd0, lvl});
    endtask

    task automatic mon_wait(input int n);
        for (int j = 0; j < n && !mon_abort; j++) begin
            @(negedge clk);
            if (rst) mon_abort = 1'b1;
        end
    endtask

    // UART monitor: samples mid-bit, abandons a byte cut short by reset.
    initial begin : monitor
        logic [7:0] b;
        logic       sb, pb;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                mon_abort = 1'b0;
                mon_wait(CPB / 2);
                sb = tx;
                for (int i = 0; i < 8; i++) begin
                    mon_wait(CPB);
                    b[i] = tx;
                end
                mon_wait(CPB);
                pb = tx;
                if (!mon_abort) begin
                    check_val("start_bit", {31'd0, sb}, 32'd0);
                    check_val("stop_bit", {31'd0, pb}, 32'd1);
                    if (sb_mode) begin
                        if (exp_q.size() == 0) check_val("byte_unexpected", {24'd0, b}, 32'h100);
                        else check_val("byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
                    end else begin
                        rx_q.push_back(b);
                    end
                end
            end
        end
    end

    initial begin
        int c;
        int t;
        int rise;
        bit done;
        rst = 1'b1;
        emotion = 8'h00;
        status  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_tx", {31'd0, tx}, 32'd1);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_frames", {24'd0, frames_sent}, 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check_val("zero_snapshot_quiet", {31'd0, busy}, 32'd0);

        // First frame and start latency
        emotion = 8'h12;
        status  = 8'h35;
        push_frame(8'h12, 8'h35);
        repeat (4) @(negedge clk);
        check_val("latency_k3_tx", {31'd0, tx}, 32'd1);
        @(negedge clk);
        check_val("latency_k4_tx", {31'd0, tx}, 32'd0);
        check_val("latency_k4_busy", {31'd0, busy}, 32'd1);
        wait_level(1'b0, 400, c);
        check_val("busy_len", c, 32'd160);
        check_val("frames_1", {24'd0, frames_sent}, 32'd1);

        // Heartbeat resend of an unchanged snapshot
        cnt0_en = 1'b1;
        push_frame(8'h12, 8'h35);
        wait_level(1'b1, 500, c);
        check_val("hb_gap", c, 32'd64);
        wait_level(1'b0, 400, c);
        check_val("busy_len_hb", c, 32'd160);
        check_val("frames_2", {24'd0, frames_sent}, 32'd2);

        // Heartbeat frames until the counter wraps
        for (int i = 0; i < 254; i++) begin
            push_frame(8'h12, 8'h35);
            wait_level(1'b1, 300, c);
            check_val("hb_gap_loop", c, 32'd64);
            wait_level(1'b0, 300, c);
        end
        check_val("frames_wrap", {24'd0, frames_sent}, 32'd0);
        cnt0_en = 1'b0;
        #1;
        check_val("nohb_busy_cycles", busy0_cnt, 32'd0);
        check_val("nohb_frames", {24'd0, frames_sent0}, 32'd1);

        // Change during a frame: bytes in flight keep the old value, next frame follows
        push_frame(8'h12, 8'h35);
        wait_level(1'b1, 300, c);
        repeat (20) @(negedge clk);
        emotion = 8'h40;
        push_frame(8'h40, 8'h35);
        wait_level(1'b0, 400, c);
        check_val("frames_after_wrap", {24'd0, frames_sent}, 32'd1);
        wait_level(1'b1, 10, c);
        check_val("rearm_gap", c, 32'd1);
        wait_level(1'b0, 400, c);
        check_val("busy_len_rearm", c, 32'd160);
        check_val("frames_rearm", {24'd0, frames_sent}, 32'd2);

        // Toggling snapshot: only a heartbeat frame, self-consistent checksum
        sb_mode = 1'b0;
        rx_q.delete();
        t = 0;
        rise = -1;
        done = 1'b0;
        while (!done && t < 400) begin
            @(negedge clk);
            emotion = (emotion == 8'h01) ? 8'h02 : 8'h01;
            t++;
            if (rise < 0 && busy) rise = t;
            if (rise >= 0 && !busy) done = 1'b1;
        end
        check_val("toggle_frame_done", {31'd0, done}, 32'd1);
        check_val("toggle_hb_only", {31'd0, (rise >= 50 && rise <= 70)}, 32'd1);
        check_val("toggle_rx_count", rx_q.size(), 32'd4);
        if (rx_q.size() == 4) begin
            check_val("toggle_sync", {24'd0, rx_q[0]}, 32'hA5);
            check_val("toggle_emotion", {31'd0, (rx_q[1] == 8'h01 || rx_q[1] == 8'h02)}, 32'd1);
            check_val("toggle_status", {24'd0, rx_q[2]}, 32'h35);
            check_val("toggle_checksum", {24'd0, rx_q[3]}, {24'd0, 8'hA5 ^ rx_q[1] ^ rx_q[2]});
        end
        check_val("frames_toggle", {24'd0, frames_sent}, 32'd3);
        sb_mode = 1'b1;
        push_frame(8'h12, 8'h35);
        emotion = 8'h12;

        // Reset pulse in the middle of a frame
        wait_level(1'b1, 50, c);
        repeat (69) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check_val("midrst_tx", {31'd0, tx}, 32'd1);
        check_val("midrst_busy", {31'd0, busy}, 32'd0);
        check_val("midrst_frames", {24'd0, frames_sent}, 32'd0);
        rst = 1'b0;
        push_frame(8'h12, 8'h35);
        repeat (4) @(posedge clk);
        #1;
        check_val("post_rst_k3_tx", {31'd0, tx}, 32'd1);
        @(posedge clk);
        #1;
        check_val("post_rst_k4_tx", {31'd0, tx}, 32'd0);
        check_val("post_rst_k4_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        wait_level(1'b0, 400, c);
        check_val("busy_len_post_rst", c, 32'd160);
        check_val("frames_post_rst", {24'd0, frames_sent}, 32'd1);

        repeat (5) @(negedge clk);
        check_val("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
